// File: rtl/apb_arbiter_if.sv
// Bus bundle for apb_arbiter: requester-side APB slave arrays plus the shared downstream APB port.
interface apb_arbiter_if #(
  parameter int mst_c = 2,
  parameter int a_w   = 12
);
  logic [mst_c-1:0][a_w-1:0] paddr_m;
  logic [mst_c-1:0][31:0]    pwdata_m;
  logic [mst_c-1:0]          psel_m;
  logic [mst_c-1:0]          pwrite_m;
  logic [mst_c-1:0]          penable_m;
  logic [mst_c-1:0]          pready_m;
  logic [mst_c-1:0][31:0]    prdata_m;

  logic [a_w-1:0]            paddr;
  logic [31:0]               pwdata;
  logic                      psel;
  logic                      pwrite;
  logic                      penable;
  logic                      pready;
  logic [31:0]               prdata;

  // slave: the arbiter's face towards the requesters; master: towards apb_router
  modport slave  (input  paddr_m, pwdata_m, psel_m, pwrite_m, penable_m,
                  output pready_m, prdata_m);
  modport master (output paddr, pwdata, psel, pwrite, penable,
                  input  pready, prdata);
endinterface

// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one downstream APB master port among mst_c requesters.
// Optional ACCESS-phase timeout built when APB_ARB_TIMEOUT_EN is defined.
module apb_arbiter #(
  parameter int mst_c  = 2,
  parameter int a_w    = 12,
  parameter int to_cyc = 16
) (
  input  logic             pclk,
  input  logic             presetn,
  apb_arbiter_if.slave     req,
  apb_arbiter_if.master    dn,
  output logic [mst_c-1:0] grant,
  output logic             to_err
);

  localparam int IW = $clog2(mst_c);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] last;
  logic [IW-1:0] own;
  logic [IW-1:0] win;
  logic          found;
  logic          done;
  logic          tmo;

  logic          unused_penable;
  assign unused_penable = ^req.penable_m;

  // Scan starts just after the previous owner, so the last winner ranks lowest.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 1; i <= mst_c; i++) begin
      if (!found && req.psel_m[(int'(last) + i) % mst_c]) begin
        found = 1'b1;
        win   = IW'((int'(last) + i) % mst_c);
      end
    end
  end

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(to_cyc + 1);
  logic [CW-1:0] to_cnt;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      to_cnt <= '0;
    end else if (state == SETUP) begin
      to_cnt <= '0;
    end else if (state == ACCESS && !dn.pready) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign tmo = (state == ACCESS) && !dn.pready && (to_cnt == CW'(to_cyc - 1));
`else
  logic [31:0] unused_to_cyc;
  assign unused_to_cyc = 32'(to_cyc);
  assign tmo = 1'b0;
`endif

  assign done = (state == ACCESS) && (dn.pready || tmo);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Response path is combinational so the winner sees completion in the same ACCESS cycle.
  always_comb begin
    req.pready_m = '0;
    req.prdata_m = '0;
    to_err       = 1'b0;
    if (done) begin
      req.pready_m[own] = 1'b1;
      req.prdata_m[own] = dn.pready ? dn.prdata : 32'hDEAD_BEEF;
      to_err            = tmo;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      dn.paddr   <= '0;
      dn.pwdata  <= '0;
      dn.pwrite  <= 1'b0;
      dn.psel    <= 1'b0;
      dn.penable <= 1'b0;
      grant      <= '0;
      own        <= '0;
      last       <= IW'(mst_c - 1);
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            dn.paddr   <= req.paddr_m[win];
            dn.pwdata  <= req.pwdata_m[win];
            dn.pwrite  <= req.pwrite_m[win];
            dn.psel    <= 1'b1;
            dn.penable <= 1'b0;
            grant      <= mst_c'(1) << win;
            own        <= win;
          end
        end
        SETUP: dn.penable <= 1'b1;
        ACCESS: begin
          if (done) begin
            dn.psel    <= 1'b0;
            dn.penable <= 1'b0;
            grant      <= '0;
            last       <= own;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Bench for apb_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_apb_arbiter;
  localparam int M  = 2;
  localparam int AW = 12;
  localparam int TO = 16;

  logic         pclk = 1'b0;
  logic         presetn;
  logic [M-1:0] grant;
  logic         to_err;

  apb_arbiter_if #(.mst_c(M), .a_w(AW)) ifc();

  apb_arbiter #(.mst_c(M), .a_w(AW), .to_cyc(TO)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .req     (ifc),
    .dn      (ifc),
    .grant   (grant),
    .to_err  (to_err)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Simple downstream slave memory capturing completed writes.
  logic [31:0] mem [0:1023];
  always @(posedge pclk) begin
    if (presetn && ifc.psel && ifc.penable && ifc.pready && ifc.pwrite)
      mem[ifc.paddr[AW-1:2]] <= ifc.pwdata;
  end

  // Transaction-level reference: one in-flight transfer, phase count since grant.
  bit              m_busy;
  int              m_ph;
  int              m_w;
  int              m_last;
  logic [AW-1:0]   x_paddr;
  logic [31:0]     x_pwdata;
  logic            x_pwrite;

  function automatic int pick(input logic [M-1:0] r, input int lst);
    for (int i = 1; i <= M; i++)
      if (r[(lst + i) % M]) return (lst + i) % M;
    return -1;
  endfunction

  always @(negedge pclk) begin : model
    logic           acc, tmo, done;
    logic [M-1:0]   e_rdy;
    logic [M*32-1:0] e_rd;
    int             p;
    if (!presetn) begin
      m_busy = 1'b0; m_ph = 0; m_w = 0; m_last = M - 1;
      x_paddr = '0; x_pwdata = '0; x_pwrite = 1'b0;
    end
    acc = m_busy && (m_ph >= 2);
    tmo = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
    tmo = acc && !ifc.pready && ((m_ph - 1) == TO);
`endif
    done  = acc && (ifc.pready || tmo);
    e_rdy = '0;
    e_rd  = '0;
    if (done) begin
      e_rdy = M'(1) << m_w;
      e_rd[m_w*32 +: 32] = ifc.pready ? ifc.prdata : 32'hDEAD_BEEF;
    end
    chk("m_psel",     64'(ifc.psel),     64'(m_busy));
    chk("m_penable",  64'(ifc.penable),  64'(acc));
    chk("m_paddr",    64'(ifc.paddr),    64'(x_paddr));
    chk("m_pwdata",   64'(ifc.pwdata),   64'(x_pwdata));
    chk("m_pwrite",   64'(ifc.pwrite),   64'(x_pwrite));
    chk("m_grant",    64'(grant),        m_busy ? 64'(M'(1) << m_w) : 64'(0));
    chk("m_pready_m", 64'(ifc.pready_m), 64'(e_rdy));
    chk("m_prdata_m", 64'(ifc.prdata_m), 64'(e_rd));
    chk("m_to_err",   64'(to_err),       64'(tmo));
    if (presetn) begin
      if (!m_busy) begin
        p = pick(ifc.psel_m, m_last);
        if (p >= 0) begin
          m_busy = 1'b1; m_ph = 1; m_w = p;
          x_paddr = ifc.paddr_m[p]; x_pwdata = ifc.pwdata_m[p]; x_pwrite = ifc.pwrite_m[p];
        end
      end else if (done) begin
        m_busy = 1'b0; m_last = m_w;
      end else begin
        m_ph++;
      end
    end
  end

  logic [M-1:0] g2 [4];
  int           n_acc;

  initial begin
    presetn = 1'b0;
    ifc.paddr_m = '0; ifc.pwdata_m = '0; ifc.psel_m = '0;
    ifc.pwrite_m = '0; ifc.penable_m = '0;
    ifc.pready = 1'b0; ifc.prdata = '0;
    tick(); tick();
    @(negedge pclk);
    chk("rst_psel",   64'(ifc.psel),     64'(0));
    chk("rst_grant",  64'(grant),        64'(0));
    chk("rst_to_err", 64'(to_err),       64'(0));
    chk("rst_rdy_m",  64'(ifc.pready_m), 64'(0));

    // 1: m0 write 0x404
    tick(); presetn = 1'b1;
    ifc.psel_m = 2'b01; ifc.paddr_m[0] = 12'h404; ifc.pwdata_m[0] = 32'h1234_5678;
    ifc.pwrite_m[0] = 1'b1; ifc.pready = 1'b1;
    @(negedge pclk); chk("t1_idle_psel", 64'(ifc.psel), 64'(0));
    tick(); @(negedge pclk);
    chk("t1_setup_psel", 64'(ifc.psel),    64'(1));
    chk("t1_setup_pen",  64'(ifc.penable), 64'(0));
    chk("t1_paddr",      64'(ifc.paddr),   64'(12'h404));
    chk("t1_grant",      64'(grant),       64'(2'b01));
    tick(); @(negedge pclk);
    chk("t1_acc_pen",    64'(ifc.penable),  64'(1));
    chk("t1_pready_m",   64'(ifc.pready_m), 64'(2'b01));
    tick(); ifc.psel_m = '0;
    chk("t1_mem", 64'(mem[10'h101]), 64'(32'h1234_5678));
    @(negedge pclk);
    chk("t1_idle_psel2", 64'(ifc.psel), 64'(0));
    chk("t1_idle_grant", 64'(grant),    64'(0));

    // 2: both request continuously after reset
    tick(); presetn = 1'b0;
    tick(); presetn = 1'b1;
    ifc.psel_m = 2'b11; ifc.pready = 1'b1;
    g2 = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int k = 0; k < 4; k++) begin
      tick(); @(negedge pclk); chk("t2_grant", 64'(grant), 64'(g2[k]));
      tick(); @(negedge pclk); chk("t2_rdy",   64'(ifc.pready_m), 64'(g2[k]));
      tick(); if (k == 3) ifc.psel_m = '0;
      @(negedge pclk); chk("t2_idle", 64'(grant), 64'(0));
    end

    // 3: m1 read 0x80C with three wait states
    tick();
    ifc.psel_m = 2'b10; ifc.paddr_m[1] = 12'h80C; ifc.pwrite_m[1] = 1'b0;
    ifc.pready = 1'b0; ifc.prdata = 32'hCAFE_0001;
    tick(); @(negedge pclk);
    chk("t3_grant", 64'(grant),     64'(2'b10));
    chk("t3_paddr", 64'(ifc.paddr), 64'(12'h80C));
    for (int a = 0; a < 3; a++) begin
      tick(); @(negedge pclk); chk("t3_wait", 64'(ifc.pready_m), 64'(0));
    end
    tick(); ifc.pready = 1'b1;
    @(negedge pclk);
    chk("t3_rdy", 64'(ifc.pready_m),    64'(2'b10));
    chk("t3_rd1", 64'(ifc.prdata_m[1]), 64'(32'hCAFE_0001));
    chk("t3_rd0", 64'(ifc.prdata_m[0]), 64'(0));

    // 4: m0 drops psel_m after being sampled
    tick(); ifc.psel_m = 2'b01; ifc.paddr_m[0] = 12'h100;
    tick(); ifc.psel_m = 2'b10;
    @(negedge pclk); chk("t4_grant", 64'(grant), 64'(2'b01));
    tick(); @(negedge pclk); chk("t4_done", 64'(ifc.pready_m), 64'(2'b01));
    tick(); @(negedge pclk); chk("t4_idle", 64'(grant), 64'(0));
    tick(); @(negedge pclk); chk("t4_next", 64'(grant), 64'(2'b10));
    tick(); ifc.psel_m = '0;
    tick();

    // 5: reset during ACCESS
    ifc.psel_m = 2'b01; ifc.pready = 1'b0;
    tick(); tick();
    #2 presetn = 1'b0;
    #1;
    chk("t5_psel",  64'(ifc.psel),    64'(0));
    chk("t5_pen",   64'(ifc.penable), 64'(0));
    chk("t5_grant", 64'(grant),       64'(0));
    ifc.psel_m = 2'b11;
    tick(); presetn = 1'b1;
    tick(); @(negedge pclk); chk("t5_first", 64'(grant), 64'(2'b01));

    // 6: pready held low in ACCESS
    tick(); ifc.psel_m = '0;
`ifdef APB_ARB_TIMEOUT_EN
    n_acc = TO;
`else
    n_acc = 20;
`endif
    for (int a = 1; a <= n_acc; a++) begin
      if (a > 1) tick();
      @(negedge pclk);
`ifdef APB_ARB_TIMEOUT_EN
      if (a < TO) begin
        chk("t6_wait_rdy", 64'(ifc.pready_m), 64'(0));
        chk("t6_wait_err", 64'(to_err),       64'(0));
      end else begin
        chk("t6_to_rdy",  64'(ifc.pready_m),    64'(2'b01));
        chk("t6_to_data", 64'(ifc.prdata_m[0]), 64'(32'hDEAD_BEEF));
        chk("t6_to_err",  64'(to_err),          64'(1));
      end
`else
      chk("t6_hold_rdy", 64'(ifc.pready_m), 64'(0));
      chk("t6_hold_err", 64'(to_err),       64'(0));
      chk("t6_hold_pen", 64'(ifc.penable),  64'(1));
`endif
    end
`ifndef APB_ARB_TIMEOUT_EN
    tick(); ifc.pready = 1'b1;
    @(negedge pclk); chk("t6_release", 64'(ifc.pready_m), 64'(2'b01));
`endif
    tick(); @(negedge pclk);
    chk("t6_idle_psel", 64'(ifc.psel), 64'(0));
    chk("t6_idle_err",  64'(to_err),   64'(0));

    // Randomized traffic; late segment starves pready to provoke long waits
    for (int n = 0; n < 3000; n++) begin
      tick();
      presetn = ($urandom_range(0, 399) != 0);
      for (int i = 0; i < M; i++) begin
        ifc.psel_m[i]    = ($urandom_range(0, 2) != 0);
        ifc.pwrite_m[i]  = $urandom_range(0, 1) != 0;
        ifc.penable_m[i] = $urandom_range(0, 1) != 0;
        ifc.paddr_m[i]   = AW'($urandom);
        ifc.pwdata_m[i]  = $urandom;
      end
      ifc.prdata = $urandom;
      if (n >= 2000) ifc.pready = ($urandom_range(0, 19) == 0);
      else           ifc.pready = ($urandom_range(0, 3) != 0);
    end

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
